// File: rtl/peripheral_bfm_slave_ahb3.sv
// Bus-functional slave memory: independent write (AW/W/B) and read (AR/R) engines over a word array.
// Optional PERIPHERAL_BFM_SLAVE_AHB3_STALL_EN delays awready/arready and throttles wready.
module peripheral_bfm_slave_ahb3 #(
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic        aclk_i,
    input  logic        areset_i,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awadr_i,
    input  logic [3:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [3:0]  wid_i,
    input  logic [31:0] wrdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    function automatic logic in_range(input logic [31:0] addr);
        return {2'b00, addr[31:2]} < MEM_DEPTH;
    endfunction

    logic [31:0] mem_q [MEM_DEPTH];

    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [3:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]  beat_err;
    logic        w_mem_we;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [3:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q, arready_d;
    logic        r_load;

    logic aw_hs, w_hs, w_last_beat, b_hs, ar_hs, r_hs;
    logic aw_open, ar_open, w_gap;

    assign aw_hs       = awvalid_i & awready_q;
    assign w_hs        = wvalid_i & wready_q;
    assign w_last_beat = w_hs & (w_cnt_q == w_len_q);
    assign b_hs        = bvalid_q & bready_i;
    assign ar_hs       = arvalid_i & arready_q;
    assign r_hs        = rvalid_q & rready_i;

`ifdef PERIPHERAL_BFM_SLAVE_AHB3_STALL_EN
    logic [7:0] aw_stall_q, aw_stall_d, ar_stall_q, ar_stall_d;
    logic       unused_in;

    // Counters restart whenever their engine is busy, so each return to idle stalls afresh.
    always_comb begin
        aw_stall_d = aw_stall_q;
        ar_stall_d = ar_stall_q;
        if (w_state_q != WIdle) begin
            aw_stall_d = '0;
        end else if (32'(aw_stall_q) < STALL_CYCLES && aw_stall_q != 8'hFF) begin
            aw_stall_d = aw_stall_q + 8'd1;
        end
        if (r_state_q != RIdle) begin
            ar_stall_d = '0;
        end else if (32'(ar_stall_q) < STALL_CYCLES && ar_stall_q != 8'hFF) begin
            ar_stall_d = ar_stall_q + 8'd1;
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            aw_stall_q <= '0;
            ar_stall_q <= '0;
        end else begin
            aw_stall_q <= aw_stall_d;
            ar_stall_q <= ar_stall_d;
        end
    end

    assign aw_open   = 32'(aw_stall_d) >= STALL_CYCLES;
    assign ar_open   = 32'(ar_stall_d) >= STALL_CYCLES;
    assign w_gap     = w_hs;
    assign unused_in = ^wid_i;
`else
    logic unused_in;
    assign aw_open   = 1'b1;
    assign ar_open   = 1'b1;
    assign w_gap     = 1'b0;
    assign unused_in = ^{wid_i, STALL_CYCLES[0]};
`endif

    // Write engine: next state
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            WIdle:   if (aw_hs) w_state_d = WData;
            WData:   if (w_last_beat) w_state_d = WResp;
            WResp:   if (b_hs) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    // Write engine: transaction bookkeeping; status codes are ordered so max() gives priority
    always_comb begin
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        beat_err  = RespOkay;
        w_mem_we  = 1'b0;
        if (aw_hs) begin
            bid_d     = awid_i;
            w_addr_d  = awadr_i;
            w_len_d   = awlen_i;
            w_burst_d = awburst_i;
            w_cnt_d   = '0;
            bresp_d   = (awsize_i != 3'b010 || awburst_i == 2'b11) ? RespSlvErr : RespOkay;
        end
        if (w_hs) begin
            w_cnt_d = w_cnt_q + 4'd1;
            if (!in_range(w_addr_q)) begin
                beat_err = RespDecErr;
            end else if (wlast_i != (w_cnt_q == w_len_q)) begin
                beat_err = RespSlvErr;
            end
            w_mem_we = in_range(w_addr_q) && (bresp_q == RespOkay);
            bresp_d  = (beat_err > bresp_q) ? beat_err : bresp_q;
            if (w_burst_q == 2'b01 || w_burst_q == 2'b10) begin
                w_addr_d = w_addr_q + 32'd4;
            end
        end
    end

    // Write engine: registered handshake outputs
    always_comb begin
        awready_d = (w_state_d == WIdle) && aw_open;
        wready_d  = (w_state_d == WData) && !w_gap;
        bvalid_d  = (w_state_d == WResp);
    end

    // Read engine: next state
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            RIdle:   if (ar_hs) r_state_d = RData;
            RData:   if (r_hs && rlast_q) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    // Read engine: r_load marks a new beat to be presented next cycle
    always_comb begin
        r_addr_d = r_addr_q;
        r_len_d  = r_len_q;
        r_cnt_d  = r_cnt_q;
        r_size_d = r_size_q;
        r_load   = 1'b0;
        if (ar_hs) begin
            r_addr_d = araddr_i;
            r_len_d  = arlen_i;
            r_size_d = arsize_i;
            r_cnt_d  = '0;
            r_load   = 1'b1;
        end else if (r_hs && !rlast_q) begin
            r_addr_d = r_addr_q + 32'd4;
            r_cnt_d  = r_cnt_q + 4'd1;
            r_load   = 1'b1;
        end
    end

    // Read engine: outputs; data sampled from mem_q before any same-edge write lands
    always_comb begin
        arready_d = (r_state_d == RIdle) && ar_open;
        rvalid_d  = (r_state_d == RData);
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        if (ar_hs) begin
            rid_d = arid_i;
        end
        if (r_load) begin
            rlast_d = (r_cnt_d == r_len_d);
            if (!in_range(r_addr_d)) begin
                rdata_d = '0;
                rresp_d = RespDecErr;
            end else if (r_size_d != 3'b010) begin
                rdata_d = '0;
                rresp_d = RespSlvErr;
            end else begin
                rdata_d = mem_q[r_addr_d[IdxW+1:2]];
                rresp_d = RespOkay;
            end
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            w_state_q <= WIdle;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            bid_q     <= '0;
            bresp_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            r_state_q <= RIdle;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge aclk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[w_addr_q[IdxW+1:2]][8*i +: 8] <= wrdata_i[8*i +: 8];
                end
            end
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign bvalid_o  = bvalid_q;
    assign arready_o = arready_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;
    assign rvalid_o  = rvalid_q;

endmodule

// File: tb/tb_peripheral_bfm_slave_ahb3.sv
// Self-checking bench for peripheral_bfm_slave_ahb3: directed cases plus randomized bursts
// checked against a word-array reference model.
module tb_peripheral_bfm_slave_ahb3;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int LIM = 100;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awid, awlen, wid, arid, arlen, bid, rid;
    logic [31:0] awadr, wrdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] model_mem [MEM_DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    peripheral_bfm_slave_ahb3 #(.MEM_DEPTH(MEM_DEPTH), .STALL_CYCLES(2)) dut (
        .aclk_i(clk), .areset_i(areset),
        .awid_i(awid), .awadr_i(awadr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
        .wid_i(wid), .wrdata_i(wrdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
        end
    endtask

    // Reference write: status from the burst rules, beats land only while no error is pending.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [2:0] size, input logic [1:0] burst);
        logic [1:0]  st;
        logic [1:0]  pre;
        logic [31:0] a;
        logic [31:0] mask;
        bit          ok;
        st = (size != 3'd2 || burst == 2'd3) ? 2'b10 : 2'b00;
        for (int i = 0; i <= len; i++) begin
            a   = (burst == 2'b00) ? addr : addr + 32'(4 * i);
            ok  = (a >> 2) < MEM_DEPTH;
            pre = st;
            if (!ok) st = 2'b11;
            else if (wl[i] != (i == len) && st != 2'b11) st = 2'b10;
            if (ok && pre == 2'b00) begin
                mask = 32'h0;
                for (int b = 0; b < 4; b++) if (ws[i][b]) mask[8*b +: 8] = 8'hFF;
                model_mem[a >> 2] = (model_mem[a >> 2] & ~mask) | (wd[i] & mask);
            end
        end
        return st;
    endfunction

    task automatic fill_beats(input int len, input bit rnd_strb);
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            wl[i] = (i == len);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input bit gaps, input bit tim);
        logic [1:0] exp_resp;
        int t;
        exp_resp = model_write(addr, len, size, burst);
        awid = id; awadr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < LIM) begin @(negedge clk); t++; end
        check_eq("aw_timeout", 32'(t >= LIM), 0);
        @(negedge clk);
        awvalid = 1'b0;
        if (tim) check_eq("wready_latency", wready, 1);
        for (int i = 0; i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            wrdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wid = $urandom; wvalid = 1'b1;
            t = 0;
            while (!wready && t < LIM) begin @(negedge clk); t++; end
            check_eq("w_timeout", 32'(t >= LIM), 0);
            @(negedge clk);
            wvalid = 1'b0;
        end
        if (tim) check_eq("bvalid_latency", bvalid, 1);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < LIM) begin @(negedge clk); t++; end
        check_eq("b_timeout", 32'(t >= LIM), 0);
        check_eq("bid", bid, id);
        check_eq("bresp", bresp, exp_resp);
        @(negedge clk);
        bready = 1'b0;
        if (tim) check_eq("awready_after_b", awready, 1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input int hold, input bit rnd,
                              input bit tim);
        logic [31:0] a, exp_d;
        logic [1:0]  exp_r;
        int t, beat, held;
        arid = id; araddr = addr; arlen = 4'(len); arsize = size; arvalid = 1'b1;
        t = 0;
        while (!arready && t < LIM) begin @(negedge clk); t++; end
        check_eq("ar_timeout", 32'(t >= LIM), 0);
        @(negedge clk);
        arvalid = 1'b0;
        if (tim) check_eq("rvalid_latency", rvalid, 1);
        beat = 0; held = 0; t = 0;
        while (beat <= len && t < 4 * LIM) begin
            if (beat == 0 && held < hold) rready = 1'b0;
            else rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rvalid) begin
                a = addr + 32'(4 * beat);
                if ((a >> 2) >= MEM_DEPTH) begin exp_d = 0; exp_r = 2'b11; end
                else if (size != 3'd2) begin exp_d = 0; exp_r = 2'b10; end
                else begin exp_d = model_mem[a >> 2]; exp_r = 2'b00; end
                check_eq("rid", rid, id);
                check_eq("rdata", rdata, exp_d);
                check_eq("rresp", rresp, exp_r);
                check_eq("rlast", rlast, (beat == len));
                if (rready) begin last_rdata = rdata; beat++; end
                else if (beat == 0) held++;
            end
            @(negedge clk);
            t++;
        end
        check_eq("r_timeout", 32'(t >= 4 * LIM), 0);
        rready = 1'b0;
        if (tim) check_eq("arready_after_r", arready, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [31:0] addr;
        logic [1:0]  burst;
        areset = 1'b1;
        awid = 0; awadr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wrdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {awready, wready, bvalid, bid, bresp, arready, rvalid,
                                 rid, rresp, rlast}, 0);
        check_eq("rst_rdata", rdata, 0);
        areset = 1'b0;
        check_eq("awready_at_release", awready, 0);
        @(negedge clk);
        check_eq("awready_after_release", awready, 1);
        check_eq("arready_after_release", arready, 1);

        // Known contents everywhere before any read.
        for (int b = 0; b < int'(MEM_DEPTH) / 16; b++) begin
            fill_beats(15, 1'b0);
            write_burst(4'(b), 32'(b * 64), 15, 3'd2, 2'b01, 1'b0, 1'b0);
        end

        fill_beats(0, 1'b0);
        wd[0] = 32'hDEADBEEF;
        write_burst(4'h5, 32'h10, 0, 3'd2, 2'b01, 1'b0, 1'b1);
        read_burst(4'h6, 32'h10, 0, 3'd2, 0, 1'b0, 1'b1);
        check_eq("single_readback", last_rdata, 32'hDEADBEEF);

        fill_beats(3, 1'b0);
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        write_burst(4'h3, 32'h0, 3, 3'd2, 2'b01, 1'b0, 1'b0);
        read_burst(4'hA, 32'h0, 3, 3'd2, 0, 1'b0, 1'b0);
        check_eq("incr_last_beat", last_rdata, 4);

        fill_beats(0, 1'b0);
        wd[0] = 32'h11223344;
        write_burst(4'h1, 32'h20, 0, 3'd2, 2'b01, 1'b0, 1'b0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        write_burst(4'h2, 32'h20, 0, 3'd2, 2'b01, 1'b0, 1'b0);
        read_burst(4'h2, 32'h20, 0, 3'd2, 0, 1'b0, 1'b0);
        check_eq("strobe_merge", last_rdata, 32'h11BB33DD);

        fill_beats(0, 1'b0);
        write_burst(4'h7, 32'(MEM_DEPTH * 4), 0, 3'd2, 2'b01, 1'b0, 1'b0);
        read_burst(4'h7, 32'(MEM_DEPTH * 4), 0, 3'd2, 0, 1'b0, 1'b0);

        fill_beats(2, 1'b0);
        wl[1] = 1'b1; wl[2] = 1'b0;
        write_burst(4'h8, 32'h40, 2, 3'd2, 2'b01, 1'b0, 1'b0);
        fill_beats(2, 1'b0);
        write_burst(4'h8, 32'h40, 2, 3'd2, 2'b01, 1'b0, 1'b0);

        fill_beats(1, 1'b0);
        write_burst(4'h9, 32'h50, 1, 3'd1, 2'b01, 1'b0, 1'b0);
        read_burst(4'h9, 32'h50, 1, 3'd2, 0, 1'b0, 1'b0);
        read_burst(4'h4, 32'h50, 0, 3'd1, 0, 1'b0, 1'b0);

        read_burst(4'hC, 32'h60, 2, 3'd2, 5, 1'b0, 1'b0);

        // Abort a 4-beat burst after two beats; those two stay in memory.
        fill_beats(3, 1'b0);
        void'(model_write(32'h80, 1, 3'd2, 2'b01));
        awid = 4'hD; awadr = 32'h80; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wrdata = wd[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        wvalid = 1'b0;
        areset = 1'b1;
        #1;
        check_eq("midrst_outputs", {awready, wready, bvalid}, 0);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check_eq("midrst_awready", awready, 1);
        check_eq("midrst_bvalid", bvalid, 0);
        read_burst(4'hE, 32'h80, 3, 3'd2, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) addr = 32'((MEM_DEPTH - $urandom_range(0, 8)) * 4);
            else addr = 32'($urandom_range(0, MEM_DEPTH - 1) * 4);
            fill_beats(len, 1'b1);
            write_burst(4'($urandom), addr, len, 3'd2, burst, 1'b1, 1'b0);
            len  = $urandom_range(0, 15);
            addr = 32'($urandom_range(0, MEM_DEPTH + 3) * 4);
            read_burst(4'($urandom), addr, len, 3'd2, 0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/peripheral_bfm_slave_ahb3.md
# peripheral_bfm_slave_ahb3

Bus-functional slave memory model that terminates the DMA bench master's write-address, write-data, write-response, read-address and read-data channels. It accepts single and burst transactions, stores write data in an internal word array with byte strobes, returns read data with correct IDs and last flags, and reports SLVERR/DECERR on malformed or out-of-range accesses. It sits directly downstream of peripheral_bfm_master_ahb3 in the MPSoC-DMA testbenches.

## Interface
- MEM_DEPTH, 256, number of 32-bit words; word index = addr[31:2], valid when index < MEM_DEPTH
- STALL_CYCLES, 2, idle cycles before awready/arready assert (used only with the stall macro)

- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awid  in  4  write ID; awadr in 32 write address; awlen in 4 beats-1; awsize in 3 beat size; awburst in 2 burst type
- awvalid in 1 / awready out 1  write-address handshake
- wid in 4 (ignored); wrdata in 32; wstrb in 4 byte enables; wlast in 1
- wvalid in 1 / wready out 1  write-data handshake
- bid out 4 response ID; bresp out 2 response; bvalid out 1 / bready in 1
- arid in 4; araddr in 32; arlen in 4; arsize in 3; arvalid in 1 / arready out 1
- rid out 4; rdata out 32; rresp out 2; rlast out 1; rvalid out 1 / rready in 1

## Operation
- Reset: all outputs 0 (awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast); both FSMs to idle; memory not reset.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; on awvalid&awready latch id, address, awlen, awburst, awsize; beat counter=0; error=OKAY.
  - W_DATA: wready=1; each wvalid&wready beat writes bytes of wrdata where wstrb[i]=1 to mem[index], unless error pending.
  - Address update per beat: awburst 2'b00 FIXED holds; 2'b01 INCR adds 4 (32-bit wrap, no carry into error); 2'b10 WRAP treated as INCR; 2'b11 -> SLVERR.
  - awsize != 3'b010 -> SLVERR, all beats discarded.
  - Any beat with index >= MEM_DEPTH -> DECERR, that beat dropped; DECERR overrides SLVERR.
  - Leave W_DATA after beat awlen+1; wlast value on that beat != 1, or wlast=1 earlier -> SLVERR (beats still counted to awlen+1).
  - W_RESP: bvalid=1, bid=latched id, bresp=accumulated status; held stable until bready; then W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE; reads always INCR.
  - R_IDLE: arready=1; on arvalid&arready latch id, address, arlen; counter=0.
  - R_DATA: rvalid=1, rid=latched id, rdata=mem[index] (0 if out of range, rresp=DECERR; arsize != 3'b010 -> SLVERR, rdata 0), rlast=1 when counter==arlen.
  - rid/rdata/rresp/rlast held stable while rvalid&!rready.
- Write and read FSMs independent and concurrent.
- Same-word read and write in the same cycle: the read beat returns the pre-write value.

## Timing
- awready/arready registered: high the cycle after the FSM enters idle (first cycle after reset release).
- AW accepted cycle N -> wready=1 from N+1; one beat per cycle max.
- Last W beat cycle M -> bvalid=1 at M+1; awready=1 the cycle after bvalid&bready.
- AR accepted cycle N -> first rvalid at N+1 with registered rdata; back-to-back beats each cycle while rready=1.
- Last R handshake cycle M -> arready=1 at M+1.
- areset mid-burst: immediate abort, outputs to 0, partial writes remain in memory.

## Configuration
- PERIPHERAL_BFM_SLAVE_AHB3_STALL_EN defined: on entering idle, awready and arready stay 0 for STALL_CYCLES cycles, then assert; additionally wready drops for one cycle after every accepted beat (one beat per two cycles).
- Undefined: no stall; behaviour as in Timing.

## Test plan
- Single write awadr=0x10, wrdata=0xDEADBEEF, wstrb=4'hF, then read araddr=0x10 -> bresp=2'b00, bid=awid; rdata=0xDEADBEEF, rlast=1, rresp=2'b00.
- INCR burst awadr=0x0, awlen=3, data 1..4, then read arlen=3 -> rdata 1,2,3,4, rlast only on beat 4, rid=arid.
- Partial strobe: word 0x20 = 0x11223344, write 0xAABBCCDD wstrb=4'b0101 -> read 0x11BB33DD.
- Out of range awadr=MEM_DEPTH*4 -> bresp=2'b11, memory untouched; read same -> rdata=0, rresp=2'b11.
- wlast early (awlen=2, wlast on beat 2) -> bresp=2'b10; awsize=3'b001 -> bresp=2'b10, no writes.
- rready held low 5 cycles on beat 1 -> rdata/rid/rlast stable; areset mid write burst -> bvalid=0, awready=1 one cycle after release.
